// File: rtl/bank_sad_reader_pkg.sv
// Shared definitions for the bank SAD reader.
// Holds the FSM state encoding and the default width constants.
package bank_sad_reader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int SAD_W  = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD_A = 2'd1;
    localparam logic [1:0] RD_B = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/bank_sad_reader_abs_diff.sv
// Combinational absolute difference of two unsigned operands.
// Ports: a_i, b_i (DATA_W operands) -> y_o = |a_i - b_i| (DATA_W).
module abs_diff #(
    parameter int DATA_W = bank_sad_reader_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    logic [DATA_W:0] diff;
    logic [DATA_W:0] neg;

    // One extra bit so the sign of a-b is visible.
    always_comb begin
        diff = {1'b0, a_i} - {1'b0, b_i};
        neg  = -diff;
        y_o  = diff[DATA_W] ? neg[DATA_W-1:0] : diff[DATA_W-1:0];
    end

endmodule

// File: rtl/bank_sad_reader.sv
// Sum of absolute differences over two byte regions of one memory bank.
// Ports: Clk, Rst_n; Start/BaseA/BaseB/Len command; Address/MemRead/
// ReadData bank side; Busy, Done pulse, Sad result.
module bank_sad_reader #(
    parameter int ADDR_W = bank_sad_reader_pkg::ADDR_W,
    parameter int DATA_W = bank_sad_reader_pkg::DATA_W,
    parameter int SAD_W  = bank_sad_reader_pkg::SAD_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseA,
    input  logic [ADDR_W-1:0] BaseB,
    input  logic [ADDR_W-1:0] Len,
    output logic [ADDR_W-1:0] Address,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData,
    output logic              Busy,
    output logic              Done,
    output logic [SAD_W-1:0]  Sad
);

    import bank_sad_reader_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [SAD_W-1:0]  acc_q, acc_d;
    logic [SAD_W-1:0]  sad_q, sad_d;

    logic [DATA_W-1:0] diff;
    logic [SAD_W-1:0]  acc_sum;

    abs_diff #(
        .DATA_W (DATA_W)
    ) u_abs_diff (
        .a_i (reg_a_q),
        .b_i (ReadData),
        .y_o (diff)
    );

    assign acc_sum = acc_q + SAD_W'(diff);

    always_comb begin
        state_d  = state_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        len_d    = len_q;
        idx_d    = idx_q;
        reg_a_d  = reg_a_q;
        acc_d    = acc_q;
        sad_d    = sad_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    base_a_d = BaseA;
                    base_b_d = BaseB;
                    len_d    = Len;
                    idx_d    = '0;
                    acc_d    = '0;
                    sad_d    = '0;
                    state_d  = (Len == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                reg_a_d = ReadData;
                state_d = RD_B;
            end
            RD_B: begin
                acc_d = acc_sum;
                // Len is nonzero here, so Len-1 cannot underflow.
                if (idx_q == len_q - ADDR_W'(1)) begin
                    sad_d   = acc_sum;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            reg_a_q  <= '0;
            acc_q    <= '0;
            sad_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            reg_a_q  <= reg_a_d;
            acc_q    <= acc_d;
            sad_q    <= sad_d;
        end
    end

    // Bank controls are decoded only from registered state,
    // address arithmetic wraps modulo the bank depth.
    always_comb begin
        Address = '0;
        MemRead = 1'b0;
        unique case (state_q)
            RD_A: begin
                Address = base_a_q + idx_q;
                MemRead = 1'b1;
            end
            RD_B: begin
                Address = base_b_q + idx_q;
                MemRead = 1'b1;
            end
            default: begin
                Address = '0;
                MemRead = 1'b0;
            end
        endcase
    end

    assign Busy = (state_q == RD_A) || (state_q == RD_B);
    assign Done = (state_q == DONE);
    assign Sad  = sad_q;

endmodule

// File: tb/tb_bank_sad_reader.sv
// Directed self-checking bench for bank_sad_reader.
// Models the 256x8 bank as a combinational array read.
module tb_bank_sad_reader;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [7:0]  BaseA;
    logic [7:0]  BaseB;
    logic [7:0]  Len;
    logic [7:0]  Address;
    logic        MemRead;
    logic [7:0]  ReadData;
    logic        Busy;
    logic        Done;
    logic [15:0] Sad;

    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    bank_sad_reader dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .BaseA    (BaseA),
        .BaseB    (BaseB),
        .Len      (Len),
        .Address  (Address),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .Busy     (Busy),
        .Done     (Done),
        .Sad      (Sad)
    );

    assign ReadData = mem[Address];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int sad_model(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input int l);
        int s;
        int d;
        logic [7:0] pa;
        logic [7:0] pb;
        s = 0;
        for (int i = 0; i < l; i++) begin
            pa = a + 8'(i);
            pb = b + 8'(i);
            d  = int'(mem[pa]) - int'(mem[pb]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    // Issues one job and follows it to Done. With glitch set, a
    // conflicting Start is pulsed mid-job and again in the Done cycle.
    task automatic run_job(input string tag,
                           input logic [7:0] a,
                           input logic [7:0] b,
                           input logic [7:0] l,
                           input int exp_sad,
                           input bit glitch);
        logic [7:0] tr [$];
        logic [7:0] ea;
        logic [7:0] eb;
        int n;
        int busy_n;
        int rd_n;
        BaseA = a;
        BaseB = b;
        Len   = l;
        Start = 1'b1;
        tick();
        Start  = 1'b0;
        n      = 1;
        busy_n = 0;
        rd_n   = 0;
        while (!Done && n < 1200) begin
            if (MemRead) begin
                tr.push_back(Address);
                rd_n++;
            end
            if (Busy) busy_n++;
            if (glitch && n == 3) begin
                Start = 1'b1;
                BaseA = 8'h80;
                BaseB = 8'h90;
                Len   = 8'd2;
            end else begin
                Start = 1'b0;
            end
            tick();
            n++;
        end
        Start = 1'b0;
        check({tag, " done"}, 32'(Done), 32'd1);
        check({tag, " latency"}, n, 2 * int'(l) + 1);
        check({tag, " busy_cycles"}, busy_n, 2 * int'(l));
        check({tag, " reads"}, rd_n, 2 * int'(l));
        check({tag, " sad"}, 32'(Sad), exp_sad);
        check({tag, " busy_at_done"}, 32'(Busy), 32'd0);
        check({tag, " memread_at_done"}, 32'(MemRead), 32'd0);
        if (tr.size() == 2 * int'(l)) begin
            for (int i = 0; i < int'(l); i++) begin
                ea = a + 8'(i);
                eb = b + 8'(i);
                check({tag, " addr_a"}, 32'(tr[2*i]), 32'(ea));
                check({tag, " addr_b"}, 32'(tr[2*i+1]), 32'(eb));
            end
        end
        if (glitch) begin
            Start = 1'b1;
            BaseA = 8'h80;
            BaseB = 8'h90;
            Len   = 8'd2;
        end
        tick();
        Start = 1'b0;
        check({tag, " done_pulse"}, 32'(Done), 32'd0);
        check({tag, " idle_busy"}, 32'(Busy), 32'd0);
        check({tag, " sad_held"}, 32'(Sad), exp_sad);
    endtask

    initial begin
        Rst_n = 1'b0;
        Start = 1'b0;
        BaseA = '0;
        BaseB = '0;
        Len   = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        #12;
        check("rst address", 32'(Address), 32'd0);
        check("rst memread", 32'(MemRead), 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst sad", 32'(Sad), 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();

        mem[8'h10] = 8'h05;
        mem[8'h20] = 8'h0A;
        run_job("single", 8'h10, 8'h20, 8'd1, 5, 1'b0);

        mem[8'h00] = 8'd1; mem[8'h01] = 8'd2;
        mem[8'h02] = 8'd3; mem[8'h03] = 8'd4;
        mem[8'h40] = 8'd4; mem[8'h41] = 8'd3;
        mem[8'h42] = 8'd2; mem[8'h43] = 8'd1;
        run_job("multi", 8'h00, 8'h40, 8'd4, 8, 1'b0);

        run_job("len0", 8'h33, 8'h44, 8'd0, 0, 1'b0);

        run_job("busy_start", 8'h00, 8'h40, 8'd4, 8, 1'b1);

        run_job("identical", 8'h00, 8'h00, 8'd4, 0, 1'b0);

        mem[8'hFE] = 8'd200; mem[8'hFF] = 8'd10;
        mem[8'h80] = 8'd50;  mem[8'h81] = 8'd60;
        mem[8'h82] = 8'd0;   mem[8'h83] = 8'd9;
        // |200-50|+|10-60|+|1-0|+|2-9| = 150+50+1+7
        check("wrap model", sad_model(8'hFE, 8'h80, 4), 208);
        run_job("wrap", 8'hFE, 8'h80, 8'd4, sad_model(8'hFE, 8'h80, 4),
                1'b0);

        // Abort in the third RD_B cycle of a Len=8 job.
        BaseA = 8'h30;
        BaseB = 8'h50;
        Len   = 8'd8;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        check("pre_abort memread", 32'(MemRead), 32'd1);
        check("pre_abort address", 32'(Address), 32'h52);
        Rst_n = 1'b0;
        #1;
        check("abort address", 32'(Address), 32'd0);
        check("abort memread", 32'(MemRead), 32'd0);
        check("abort busy", 32'(Busy), 32'd0);
        check("abort done", 32'(Done), 32'd0);
        check("abort sad", 32'(Sad), 32'd0);
        begin
            int done_seen;
            done_seen = 0;
            repeat (3) begin
                tick();
                if (Done) done_seen++;
            end
            Rst_n = 1'b1;
            repeat (3) begin
                tick();
                if (Done) done_seen++;
            end
            check("abort no_done", done_seen, 0);
        end
        run_job("post_reset", 8'h10, 8'h20, 8'd1, 5, 1'b0);

        // Alternating FF/00 makes every pair of (i, i+1) differ by 255.
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
        run_job("max", 8'h00, 8'h01, 8'd255, 65025, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
